// File: rtl/voice_allocator_if.sv
// Request channel between the keyboard/MIDI front end and the voice allocator.
// Ports: req_valid/req_on/req_note/req_freq from master, req_ready from slave.
interface voice_allocator_if #(
    parameter int NOTE_BITS = 7,
    parameter int FREQ_BITS = 16
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_on;
    logic [NOTE_BITS-1:0] req_note;
    logic [FREQ_BITS-1:0] req_freq;

    modport master (
        output req_valid, req_on, req_note, req_freq,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_on, req_note, req_freq,
        output req_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger, free-voice and oldest-voice stealing.
// Ports: main_clk, reset, panic, req (slave), voice_freq/gate/sync, steal, active_count.
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int FREQ_BITS  = 16,
    parameter int NOTE_BITS  = 7,
    parameter int AGE_BITS   = 4
) (
    input  logic                             main_clk,
    input  logic                             reset,
    input  logic                             panic,
    voice_allocator_if.slave                 req,
    output logic [NUM_VOICES*FREQ_BITS-1:0]  voice_freq,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES-1:0]            voice_sync,
    output logic                             steal,
    output logic [3:0]                       active_count
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_ON, ACT_OFF} act_t;

    state_t state, state_nx;
    logic   accept;

    logic                 lat_on;
    logic [NOTE_BITS-1:0] lat_note;
    logic [FREQ_BITS-1:0] lat_freq;

    act_t             act, look_act;
    logic [IDX_W-1:0] tgt, look_tgt;
    logic             pend_steal, look_steal;

    logic [FREQ_BITS-1:0] freq [NUM_VOICES];
    logic [NOTE_BITS-1:0] note [NUM_VOICES];
    logic [AGE_BITS-1:0]  age  [NUM_VOICES];
    logic [AGE_BITS-1:0]  age_nx [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate, gate_nx;

    logic                 hit, free, old;
    logic [IDX_W-1:0]     hit_idx, free_idx, old_idx;
    logic [AGE_BITS-1:0]  old_age;

    function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_VOICES; i++) c = c + 4'(v[i]);
        return c;
    endfunction

    assign req.req_ready = (state == IDLE) && !reset && !panic;
    assign accept        = req.req_valid && req.req_ready;

    always_ff @(posedge main_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (panic) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = LOOKUP;
                LOOKUP:  state_nx = APPLY;
                APPLY:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Scan the bank for a note match, the first free voice and the oldest gated voice.
    // Strict '>' keeps the lowest index on age ties (including saturated ages).
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        old      = 1'b0;
        old_idx  = '0;
        old_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate[i] && note[i] == lat_note && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!gate[i] && !free) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (gate[i] && (!old || age[i] > old_age)) begin
                old     = 1'b1;
                old_idx = IDX_W'(i);
                old_age = age[i];
            end
        end
    end

    always_comb begin
        look_act   = ACT_NONE;
        look_tgt   = '0;
        look_steal = 1'b0;
        if (lat_on) begin
            look_act = ACT_ON;
            if (hit) begin
                look_tgt = hit_idx;
            end else if (free) begin
                look_tgt = free_idx;
            end else begin
                look_tgt   = old_idx;
                look_steal = 1'b1;
            end
        end else if (hit) begin
            look_act = ACT_OFF;
            look_tgt = hit_idx;
        end
    end

    always_comb begin
        gate_nx = gate;
        for (int i = 0; i < NUM_VOICES; i++) age_nx[i] = age[i];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (act == ACT_ON) begin
                if (i == int'(tgt)) begin
                    gate_nx[i] = 1'b1;
                    age_nx[i]  = '0;
                end else if (gate[i] && age[i] != AGE_MAX) begin
                    age_nx[i] = age[i] + 1'b1;
                end
            end else if (act == ACT_OFF && i == int'(tgt)) begin
                gate_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            lat_on       <= 1'b0;
            lat_note     <= '0;
            lat_freq     <= '0;
            act          <= ACT_NONE;
            tgt          <= '0;
            pend_steal   <= 1'b0;
            gate         <= '0;
            voice_sync   <= '0;
            steal        <= 1'b0;
            active_count <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq[i] <= '0;
                note[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            voice_sync <= '0;
            steal      <= 1'b0;
            if (accept) begin
                lat_on   <= req.req_on;
                lat_note <= req.req_note;
                lat_freq <= req.req_freq;
            end
            if (state == LOOKUP) begin
                act        <= look_act;
                tgt        <= look_tgt;
                pend_steal <= look_steal;
            end
            if (panic) begin
                gate         <= '0;
                active_count <= '0;
            end else if (state == APPLY) begin
                gate         <= gate_nx;
                active_count <= popcount(gate_nx);
                for (int i = 0; i < NUM_VOICES; i++) age[i] <= age_nx[i];
                if (act == ACT_ON) begin
                    steal <= pend_steal;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (i == int'(tgt)) begin
                            freq[i]       <= lat_freq;
                            note[i]       <= lat_note;
                            voice_sync[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_freq
        assign voice_freq[g*FREQ_BITS +: FREQ_BITS] = freq[g];
    end

    assign voice_gate = gate;
endmodule
